// File: rtl/muldiv_seq_pkg.sv
// Shared muldiv constants: RV32M op codes, sequencer state encodings,
// and the state enum / op helpers used by the sequencer and its users.
`ifndef MULDIV_SEQ_DEFS
`define MULDIV_SEQ_DEFS
`define MUL      5'd1
`define DIV      5'd2
`define DIVU     5'd3
`define REM      5'd4
`define REMU     5'd5
`define MDS_IDLE 2'd0
`define MDS_CALC 2'd1
`define MDS_DONE 2'd2
`endif

package muldiv_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = `MDS_IDLE,
        ST_CALC = `MDS_CALC,
        ST_DONE = `MDS_DONE
    } mds_state_e;

    localparam logic [4:0] OP_MUL  = `MUL;
    localparam logic [4:0] OP_DIV  = `DIV;
    localparam logic [4:0] OP_DIVU = `DIVU;
    localparam logic [4:0] OP_REM  = `REM;
    localparam logic [4:0] OP_REMU = `REMU;

    function automatic logic is_m_op(input logic [4:0] op);
        return (op == `MUL) || (op == `DIV) || (op == `DIVU) ||
               (op == `REM) || (op == `REMU);
    endfunction

    function automatic logic is_rem_op(input logic [4:0] op);
        return (op == `REM) || (op == `REMU);
    endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// Request/response handshake bundle between the execute stage and
// the multi-cycle mul/div sequencer.
interface muldiv_seq_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic [4:0]      operation;
    logic [XLEN-1:0] ip1;
    logic [XLEN-1:0] ip2;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] result;
    logic            zero_flag;

    modport master (
        output req_valid, operation, ip1, ip2, resp_ready,
        input  req_ready, resp_valid, result, zero_flag
    );

    modport slave (
        input  req_valid, operation, ip1, ip2, resp_ready,
        output req_ready, resp_valid, result, zero_flag
    );
endinterface

// File: rtl/muldiv_step.sv
// One iteration on the {acc, q} pair: shift-add multiply (right shift)
// or restoring shift-subtract divide (left shift, quotient bit into q).
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic            is_mul,
    input  logic [XLEN-1:0] acc_i,
    input  logic [XLEN-1:0] q_i,
    input  logic [XLEN-1:0] opnd_i,
    output logic [XLEN-1:0] acc_o,
    output logic [XLEN-1:0] q_o
);
    logic [XLEN:0] sum;
    logic [XLEN:0] rem_sh;
    logic          ge;

    always_comb begin
        sum    = {1'b0, acc_i} + (q_i[0] ? {1'b0, opnd_i} : '0);
        rem_sh = {acc_i, q_i[XLEN-1]};
        ge     = rem_sh >= {1'b0, opnd_i};
        acc_o  = '0;
        q_o    = '0;
        if (is_mul) begin
            acc_o = sum[XLEN:1];
            q_o   = {sum[0], q_i[XLEN-1:1]};
        end else if (ge) begin
            // remainder < divisor, so the difference fits in XLEN bits
            acc_o = XLEN'(rem_sh - {1'b0, opnd_i});
            q_o   = {q_i[XLEN-2:0], 1'b1};
        end else begin
            acc_o = rem_sh[XLEN-1:0];
            q_o   = {q_i[XLEN-2:0], 1'b0};
        end
    end
endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV32M MUL/DIV/DIVU/REM/REMU sequencer with valid/ready handshake.
// MULDIV_FAST_MUL_EN: MUL done by a single-cycle multiplier at accept.
module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        kill,
    output logic        busy,
    muldiv_seq_if.slave bus
);
    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

    mds_state_e      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [4:0]      op_q, op_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic            negq_q, negq_d;
    logic            negr_q, negr_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            zero_q, zero_d;

    logic            accept;
    logic            in_sgn, n1, n2, sp, in_mul;
    logic [XLEN-1:0] abs1, abs2, sp_res;
    logic [XLEN-1:0] acc_s, quo_s, fin;

    muldiv_step #(.XLEN(XLEN)) u_step (
        .is_mul (op_q == `MUL),
        .acc_i  (acc_q),
        .q_i    (quo_q),
        .opnd_i (dvs_q),
        .acc_o  (acc_s),
        .q_o    (quo_s)
    );

    assign bus.req_ready  = (state_q == ST_IDLE) && !kill;
    assign accept         = bus.req_valid && bus.req_ready;
    assign bus.resp_valid = (state_q == ST_DONE);
    assign bus.result     = result_q;
    assign bus.zero_flag  = zero_q;
    assign busy           = (state_q != ST_IDLE);

    // operand magnitudes and the single-cycle special results
    always_comb begin
        in_mul = (bus.operation == `MUL);
        in_sgn = (bus.operation == `DIV) || (bus.operation == `REM);
        n1     = in_sgn && bus.ip1[XLEN-1];
        n2     = in_sgn && bus.ip2[XLEN-1];
        abs1   = n1 ? -bus.ip1 : bus.ip1;
        abs2   = n2 ? -bus.ip2 : bus.ip2;
        sp     = 1'b0;
        sp_res = '0;
        if (!is_m_op(bus.operation)) begin
            sp = 1'b1;
        end else if (!in_mul && bus.ip2 == '0) begin
            sp     = 1'b1;
            sp_res = is_rem_op(bus.operation) ? bus.ip1 : '1;
        end else if (in_sgn && bus.ip1 == SMIN && bus.ip2 == '1) begin
            sp     = 1'b1;
            sp_res = (bus.operation == `DIV) ? SMIN : '0;
        end
`ifdef MULDIV_FAST_MUL_EN
        else if (in_mul) begin
            sp     = 1'b1;
            sp_res = bus.ip1 * bus.ip2;
        end
`endif
    end

    always_comb begin
        fin = acc_s;
        if (op_q == `MUL) begin
            fin = quo_s;
        end else if (op_q == `DIV || op_q == `DIVU) begin
            fin = negq_q ? -quo_s : quo_s;
        end else begin
            fin = negr_q ? -acc_s : acc_s;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        acc_d    = acc_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        negq_d   = negq_q;
        negr_d   = negr_q;
        result_d = result_q;
        zero_d   = zero_q;
        if (kill) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        op_d = bus.operation;
                        if (sp) begin
                            state_d  = ST_DONE;
                            result_d = sp_res;
                            zero_d   = (sp_res == '0);
                        end else begin
                            state_d = ST_CALC;
                            cnt_d   = CW'(XLEN);
                            acc_d   = '0;
                            quo_d   = in_mul ? bus.ip2 : abs1;
                            dvs_d   = in_mul ? bus.ip1 : abs2;
                            negq_d  = n1 ^ n2;
                            negr_d  = n1;
                        end
                    end
                end
                ST_CALC: begin
                    acc_d = acc_s;
                    quo_d = quo_s;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        state_d  = ST_DONE;
                        result_d = fin;
                        zero_d   = (fin == '0);
                    end
                end
                ST_DONE: begin
                    if (bus.resp_ready) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            acc_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            negq_q   <= negq_d;
            negr_q   <= negr_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end
endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed table, random ops against
// an arithmetic reference model, back-pressure, kill and async reset.
module tb_muldiv_seq;
    import muldiv_seq_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    logic clk;
    logic rst_n;
    logic kill;
    logic busy;
    int   checks;
    int   failures;

    muldiv_seq_if #(.XLEN(32)) bus ();

    muldiv_seq #(.XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .kill  (kill),
        .busy  (busy),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
    } vec_t;

    vec_t tbl[13];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_res(input logic [4:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        int sa;
        int sb;
        sa = a;
        sb = b;
        case (op)
            OP_MUL:  return a * b;
            OP_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            OP_REMU: return (b == 0) ? a : a % b;
            OP_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return 32'(sa / sb);
            end
            OP_REM: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
                return 32'(sa % sb);
            end
            default: return 0;
        endcase
    endfunction

    function automatic int ref_lat(input logic [4:0] op,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
        if (op == OP_MUL) return MUL_LAT;
        if (!(op == OP_DIV || op == OP_DIVU || op == OP_REM || op == OP_REMU))
            return 1;
        if (b == 0) return 1;
        if ((op == OP_DIV || op == OP_REM) &&
            a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // called at a negedge with the DUT idle; returns at a negedge, idle again
    task automatic run_op(input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, output logic [31:0] r,
                          output logic z, output int lat);
        check("req_ready_before_op", bus.req_ready, 1'b1);
        bus.operation  = op;
        bus.ip1        = a;
        bus.ip2        = b;
        bus.req_valid  = 1'b1;
        bus.resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.ip1       = $urandom;
        bus.ip2       = $urandom;
        bus.operation = 5'($urandom);
        lat = 1;
        while (!bus.resp_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        r = bus.result;
        z = bus.zero_flag;
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] r;
        logic        z;
        int          lat;
        int          cnt;
        logic [4:0]  ops[5];
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  op;
        string       nm;

        checks         = 0;
        failures       = 0;
        ops            = '{OP_MUL, OP_DIV, OP_DIVU, OP_REM, OP_REMU};
        rst_n          = 1'b0;
        kill           = 1'b0;
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b1;
        bus.operation  = '0;
        bus.ip1        = '0;
        bus.ip2        = '0;

        tbl[0]  = '{OP_DIVU, 32'd100, 32'd7, 32'd14, 33};
        tbl[1]  = '{OP_REMU, 32'd100, 32'd7, 32'd2, 33};
        tbl[2]  = '{OP_DIV, -32'sd7, 32'd2, 32'hFFFF_FFFD, 33};
        tbl[3]  = '{OP_REM, -32'sd7, 32'd2, 32'hFFFF_FFFF, 33};
        tbl[4]  = '{OP_DIV, 32'd7, -32'sd2, 32'hFFFF_FFFD, 33};
        tbl[5]  = '{OP_REM, 32'd7, -32'sd2, 32'd1, 33};
        tbl[6]  = '{OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1};
        tbl[7]  = '{OP_REMU, 32'd5, 32'd0, 32'd5, 1};
        tbl[8]  = '{OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
        tbl[9]  = '{OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1};
        tbl[10] = '{OP_MUL, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, MUL_LAT};
        tbl[11] = '{5'd31, 32'd3, 32'd4, 32'd0, 1};
        tbl[12] = '{OP_DIVU, 32'd3, 32'd9, 32'd0, 33};

        repeat (2) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_resp_valid", bus.resp_valid, 1'b0);
        check("rst_result", bus.result, 32'd0);
        check("rst_zero_flag", bus.zero_flag, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_req_ready", bus.req_ready, 1'b1);

        for (int i = 0; i < 13; i++) begin
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, r, z, lat);
            nm = $sformatf("vec%0d", i);
            check({nm, "_result"}, r, tbl[i].res);
            check({nm, "_zero"}, z, tbl[i].res == 0);
            check({nm, "_latency"}, lat, tbl[i].lat);
        end

        for (int i = 0; i < 60; i++) begin
            op = ops[$urandom_range(0, 4)];
            a  = $urandom;
            if (($urandom & 3) == 0) a = -32'($urandom_range(1, 1000));
            case ($urandom_range(0, 4))
                0: b = $urandom;
                1: b = $urandom_range(1, 15);
                2: b = 0;
                3: b = -32'($urandom_range(1, 9));
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            run_op(op, a, b, r, z, lat);
            nm = $sformatf("rnd%0d_op%0d", i, op);
            check({nm, "_result"}, r, ref_res(op, a, b));
            check({nm, "_zero"}, z, ref_res(op, a, b) == 0);
            check({nm, "_latency"}, lat, ref_lat(op, a, b));
        end

        // back-pressure: result held, no new request taken
        bus.resp_ready = 1'b0;
        bus.operation  = OP_DIVU;
        bus.ip1        = 32'd100;
        bus.ip2        = 32'd7;
        bus.req_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        cnt = 0;
        while (!bus.resp_valid && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        check("bp_first_valid", bus.resp_valid, 1'b1);
        for (int i = 0; i < 5; i++) begin
            bus.operation = OP_REMU;
            bus.ip1       = 32'd9;
            bus.ip2       = 32'd4;
            bus.req_valid = 1'b1;
            @(negedge clk);
            check("bp_resp_valid", bus.resp_valid, 1'b1);
            check("bp_result", bus.result, 32'd14);
            check("bp_req_ready", bus.req_ready, 1'b0);
        end
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        check("bp_after_req_ready", bus.req_ready, 1'b1);
        check("bp_after_resp_valid", bus.resp_valid, 1'b0);
        check("bp_after_busy", busy, 1'b0);

        // kill in the tenth CALC cycle
        bus.operation = OP_DIVU;
        bus.ip1       = 32'd1000;
        bus.ip2       = 32'd3;
        bus.req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (9) @(negedge clk);
        check("kill_busy_before", busy, 1'b1);
        kill          = 1'b1;
        bus.req_valid = 1'b1;
        @(negedge clk);
        kill          = 1'b0;
        bus.req_valid = 1'b0;
        check("kill_busy", busy, 1'b0);
        check("kill_result_kept", bus.result, 32'd14);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.resp_valid) cnt++;
        end
        check("kill_no_resp_valid", cnt, 0);
        check("kill_idle", busy, 1'b0);

        // async reset in the middle of CALC
        bus.operation = OP_DIVU;
        bus.ip1       = 32'd100;
        bus.ip2       = 32'd7;
        bus.req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_resp_valid", bus.resp_valid, 1'b0);
        check("arst_result", bus.result, 32'd0);
        check("arst_zero_flag", bus.zero_flag, 1'b0);
        check("arst_busy", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("arst_req_ready", bus.req_ready, 1'b1);
        run_op(OP_DIVU, 32'd100, 32'd7, r, z, lat);
        check("post_rst_result", r, 32'd14);
        check("post_rst_latency", lat, 33);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
